spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Byte-stream command decoder sitting directly downstream of `spi_slave`: consumes its `byte_vld`/`byte_data` stream, frames it with chip-select, and turns it into configuration-register writes, sequential pixel-RAM writes and a readback byte for MISO. Its outputs feed the LED frame RAM and the NeoPixel waveform generator.

## Interface
- `DEPTH`, 768: pixel RAM depth in bytes (any value ≥ 2, need not be a power of two).
- `ADDR_WIDTH`, `$clog2(DEPTH)`: RAM address width.
- `DEV_ID`, 8'hA5: identity byte returned by INFO_RD.
- `CONF_RST`, 8'h00: reset value of `conf_o`.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `spi_cs_n_i`  in  1  raw SPI chip select, asynchronous to `clk_i`.
- `spi_byte_vld_i`  in  1  one-cycle pulse from `spi_slave`: a received byte is valid.
- `spi_byte_data_i`  in  8  received byte, valid with `spi_byte_vld_i`.
- `spi_byte_data_o`  out  8  next byte for `spi_slave` to shift out on MISO.
- `ram_wr_en_o`  out  1  pixel RAM write strobe.
- `ram_wr_addr_o`  out  ADDR_WIDTH  pixel RAM write address.
- `ram_wr_data_o`  out  8  pixel RAM write data.
- `conf_o`  out  8  configuration register.
- `frame_done_o`  out  1  one-cycle pulse: a DATA_WR frame ended with at least one byte written.
- `ovf_o`  out  1  sticky: DATA_WR exceeded DEPTH bytes; cleared by the next DATA_WR command byte.

## Operation
- `spi_cs_n_i` passes through a 2-FF synchronizer (reset value 1). Frame end = rising edge of the synchronized signal.
- States: IDLE (expect command byte), CONF, DATA, INFO, DISCARD. Transitions occur only on `spi_byte_vld_i`, except frame end.
- IDLE:
  - 0x2A: go to CONF.
  - 0x2B: clear address counter and `ovf_o`, go to DATA.
  - 0x2C: load `spi_byte_data_o <= DEV_ID`, go to INFO.
  - Any other byte: go to DISCARD.
- CONF: payload byte is written to `conf_o`, then IDLE. Another command may follow in the same frame.
- DATA: each byte writes the RAM at the current address, then the address increments.
  - The byte written at `DEPTH-1` is stored normally.
  - Any further byte sets `ovf_o`, is not written, and moves the state to DISCARD.
  - The address never wraps.
- INFO: the next received byte (a dummy) loads `spi_byte_data_o <= conf_o` and moves the state to DISCARD. `spi_byte_data_o` returns to 0x00 at frame end.
- DISCARD: bytes are ignored until frame end.
- Frame end, from any state:
  - Go to IDLE and set `spi_byte_data_o <= 0x00`.
  - If the state was DATA or DISCARD-after-DATA and the frame wrote ≥1 byte, pulse `frame_done_o`.
- Simultaneous `spi_byte_vld_i` and frame end: the byte is processed under the current state first (its write and its count toward `frame_done_o` included), then the state returns to IDLE.
- `spi_byte_vld_i` while synchronized CS is high is ignored.

## Timing
- Reset values:
  - State = IDLE, address = 0, written-byte flag = 0.
  - `ram_wr_en_o` = 0, `ram_wr_addr_o` = 0, `ram_wr_data_o` = 0x00.
  - `conf_o` = CONF_RST, `frame_done_o` = 0, `ovf_o` = 0, `spi_byte_data_o` = 0x00.
- All outputs are registered. `ram_wr_en_o`/`addr`/`data` are valid exactly 1 cycle after `spi_byte_vld_i`. The strobe lasts 1 cycle.
- `conf_o` and `spi_byte_data_o` update 1 cycle after the triggering `spi_byte_vld_i`.
- `frame_done_o` pulses 1 cycle after the synchronized rising edge, i.e. 3 `clk_i` cycles after `spi_cs_n_i` rises.
- Back-to-back `spi_byte_vld_i` on consecutive cycles are all accepted, with no stall.
- Reset mid-frame: everything returns to reset values on the next edge. The partially written frame produces no `frame_done_o`.

## Test plan
- CONF then DATA in one frame: bytes 0x2A, 0x2B, then 0x11: `conf_o`=0x2B; 0x11 is treated as a command and discarded; no RAM write; no `frame_done_o`.
- DATA frame: bytes 0x2B, 0x01, 0x02, 0x03, then CS high: three writes at addr 0/1/2 with data 01/02/03, each 1 cycle after vld; one `frame_done_o` pulse 3 cycles after CS rises.
- Overflow with DEPTH=4: 0x2B plus six data bytes: four writes (addr 0..3); `ovf_o`=1 after the fifth byte; no further writes; `frame_done_o` pulses; a new 0x2B frame clears `ovf_o`.
- INFO readback with `conf_o`=0x5C: bytes 0x2C, 0x00, 0x00: `spi_byte_data_o` = 0xA5 after the first byte, 0x5C after the second, unchanged after the third, 0x00 after CS high.
- Unknown command 0x7F followed by 0x2B, 0xFF: no writes; `conf_o` unchanged; no `frame_done_o`.
- Edge cases:
  - vld coincident with the synchronized CS rise on the last DATA byte: the byte is written and `frame_done_o` pulses.
  - `rst_i` asserted mid-DATA: outputs return to reset values and no pulse is produced.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// Command decoder behind spi_slave: frames the received byte stream with chip-select
// and turns it into config writes, sequential pixel-RAM writes and MISO readback.
module spi_cmd_decoder #(
  parameter int         DEPTH      = 768,
  parameter int         ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [7:0] DEV_ID     = 8'hA5,
  parameter logic [7:0] CONF_RST   = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_byte_vld_i,
  input  logic [7:0]            spi_byte_data_i,
  output logic [7:0]            spi_byte_data_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [7:0]            ram_wr_data_o,
  output logic [7:0]            conf_o,
  output logic                  frame_done_o,
  output logic                  ovf_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [7:0] CMD_CONF = 8'h2A;
  localparam logic [7:0] CMD_DATA = 8'h2B;
  localparam logic [7:0] CMD_INFO = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONF,
    ST_DATA,
    ST_INFO,
    ST_DISCARD
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  written_q, written_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            conf_q, conf_d;
  logic [7:0]            rd_q, rd_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic cs_meta, cs_sync, cs_prev;
  logic cs_rise, accept;

  // cs_prev is the edge-detect stage; a byte arriving in the rise cycle still belongs to the frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge value,
      // so this shift chain really is three stages rather than collapsing into one.
      cs_meta <= spi_cs_n_i;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_rise = cs_sync & ~cs_prev;
  assign accept  = spi_byte_vld_i & (~cs_sync | cs_rise);

  always_comb begin
    // NOTE: every value driven here gets a default first; a path that skips an
    // assignment would otherwise infer a latch to hold the old value.
    state_d   = state_q;
    count_d   = count_q;
    written_d = written_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    conf_d    = conf_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (spi_byte_data_i)
            CMD_CONF: state_d = ST_CONF;
            CMD_DATA: begin
              count_d   = '0;
              written_d = 1'b0;
              ovf_d     = 1'b0;
              state_d   = ST_DATA;
            end
            CMD_INFO: begin
              rd_d    = DEV_ID;
              state_d = ST_INFO;
            end
            default:  state_d = ST_DISCARD;
          endcase
        end
        ST_CONF: begin
          conf_d  = spi_byte_data_i;
          state_d = ST_IDLE;
        end
        ST_DATA: begin
          // The count saturates at DEPTH; the address is never allowed to wrap.
          if (count_q < DEPTH_C) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_WIDTH-1:0];
            wr_data_d = spi_byte_data_i;
            count_d   = count_q + CNT_W'(1);
            written_d = 1'b1;
          end else begin
            ovf_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_INFO: begin
          rd_d    = conf_q;
          state_d = ST_DISCARD;
        end
        default: ;
      endcase
    end

    // Frame end is applied after the byte so a coincident last byte still counts.
    if (cs_rise) begin
      done_d    = ((state_q == ST_DATA) || (state_q == ST_DISCARD)) && written_d;
      written_d = 1'b0;
      rd_d      = 8'h00;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      written_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      conf_q    <= CONF_RST;
      rd_q      <= 8'h00;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      written_q <= written_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      conf_q    <= conf_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign spi_byte_data_o = rd_q;
  assign ram_wr_en_o     = wr_en_q;
  assign ram_wr_addr_o   = wr_addr_q;
  assign ram_wr_data_o   = wr_data_q;
  assign conf_o          = conf_q;
  assign frame_done_o    = done_q;
  assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frame table, hand-written corner
// sequences and random frames compared against a command-parsing reference model.
module tb_spi_cmd_decoder;

  localparam int         DEPTH    = 4;
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] DEV_ID   = 8'hA5;
  localparam logic [7:0] CONF_RST = 8'h00;
  localparam int         MAXB     = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          spi_cs_n_i = 1'b1;
  logic          spi_byte_vld_i = 1'b0;
  logic [7:0]    spi_byte_data_i = 8'h00;
  logic [7:0]    spi_byte_data_o;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [7:0]    ram_wr_data_o;
  logic [7:0]    conf_o;
  logic          frame_done_o;
  logic          ovf_o;

  spi_cmd_decoder #(
    .DEPTH   (DEPTH),
    .DEV_ID  (DEV_ID),
    .CONF_RST(CONF_RST)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .spi_cs_n_i     (spi_cs_n_i),
    .spi_byte_vld_i (spi_byte_vld_i),
    .spi_byte_data_i(spi_byte_data_i),
    .spi_byte_data_o(spi_byte_data_o),
    .ram_wr_en_o    (ram_wr_en_o),
    .ram_wr_addr_o  (ram_wr_addr_o),
    .ram_wr_data_o  (ram_wr_data_o),
    .conf_o         (conf_o),
    .frame_done_o   (frame_done_o),
    .ovf_o          (ovf_o)
  );

  always #5 clk = ~clk;

  typedef logic [MAXB-1:0][7:0] frame_t;

  typedef struct {
    frame_t     b;
    int         n;
    logic [7:0] conf;
    bit         done;
    bit         ovf;
    int         writes;
    logic [7:0] rd_last;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state, carried across frames.
  logic [7:0] m_conf = CONF_RST;
  bit         m_ovf = 1'b0;

  // Per-byte expectations for the frame being run.
  bit         e_we   [MAXB];
  int         e_addr [MAXB];
  logic [7:0] e_wd   [MAXB];
  logic [7:0] e_rd   [MAXB];
  logic [7:0] e_conf [MAXB];
  bit         e_ovf  [MAXB];
  bit         e_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Parses the frame as a command list and derives what each byte should cause.
  task automatic model_frame(input frame_t fb, input int n);
    int         i;
    int         rem;
    int         w;
    logic [7:0] conf;
    conf   = m_conf;
    e_done = 1'b0;
    for (int k = 0; k < MAXB; k++) begin
      e_we[k]   = 1'b0;
      e_addr[k] = 0;
      e_wd[k]   = 8'h00;
      e_rd[k]   = 8'h00;
      e_conf[k] = m_conf;
      e_ovf[k]  = m_ovf;
    end
    i = 0;
    while (i < n) begin
      if (fb[i] == 8'h2A) begin
        if (i + 1 < n) begin
          conf = fb[i+1];
          for (int k = i + 1; k < MAXB; k++) e_conf[k] = conf;
        end
        i += 2;
      end else if (fb[i] == 8'h2B) begin
        for (int k = i; k < MAXB; k++) e_ovf[k] = 1'b0;
        rem = n - i - 1;
        w   = (rem < DEPTH) ? rem : DEPTH;
        for (int j = 0; j < w; j++) begin
          e_we[i+1+j]   = 1'b1;
          e_addr[i+1+j] = j;
          e_wd[i+1+j]   = fb[i+1+j];
        end
        if (rem > DEPTH)
          for (int k = i + 1 + DEPTH; k < MAXB; k++) e_ovf[k] = 1'b1;
        e_done = (w > 0);
        i = n;
      end else if (fb[i] == 8'h2C) begin
        e_rd[i] = DEV_ID;
        for (int k = i + 1; k < MAXB; k++) e_rd[k] = conf;
        i = n;
      end else begin
        i = n;
      end
    end
    m_conf = conf;
    m_ovf  = e_ovf[n-1];
  endtask

  task automatic run_frame(input frame_t fb, input int n, input int max_gap,
                           output int writes, output bit saw_done, output logic [7:0] last_rd);
    int gap;
    writes   = 0;
    saw_done = 1'b0;
    model_frame(fb, n);
    spi_cs_n_i = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < n; k++) begin
      spi_byte_vld_i  = 1'b1;
      spi_byte_data_i = fb[k];
      tick();
      spi_byte_vld_i  = 1'b0;
      check("wr_en", 32'(ram_wr_en_o), 32'(e_we[k]));
      if (e_we[k]) begin
        check("wr_addr", 32'(ram_wr_addr_o), 32'(e_addr[k]));
        check("wr_data", 32'(ram_wr_data_o), 32'(e_wd[k]));
      end
      if (ram_wr_en_o) writes++;
      check("conf", 32'(conf_o), 32'(e_conf[k]));
      check("readback", 32'(spi_byte_data_o), 32'(e_rd[k]));
      check("ovf", 32'(ovf_o), 32'(e_ovf[k]));
      check("done_mid_frame", 32'(frame_done_o), 32'(0));
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        tick();
        check("wr_en_idle", 32'(ram_wr_en_o), 32'(0));
      end
    end
    last_rd = spi_byte_data_o;
    spi_cs_n_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("frame_done_timing", 32'(frame_done_o), (t == 3) ? 32'(e_done) : 32'(0));
      check("wr_en_after_cs", 32'(ram_wr_en_o), 32'(0));
      if (frame_done_o) saw_done = 1'b1;
      if (t == 3) check("readback_cleared", 32'(spi_byte_data_o), 32'(0));
    end
    check("ovf_end", 32'(ovf_o), 32'(m_ovf));
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5, b6,
                              input logic [7:0] conf, input bit done, input bit ovf,
                              input int writes, input logic [7:0] rd_last);
    vec_t v;
    v.b       = '0;
    v.b[0]    = b0;
    v.b[1]    = b1;
    v.b[2]    = b2;
    v.b[3]    = b3;
    v.b[4]    = b4;
    v.b[5]    = b5;
    v.b[6]    = b6;
    v.n       = n;
    v.conf    = conf;
    v.done    = done;
    v.ovf     = ovf;
    v.writes  = writes;
    v.rd_last = rd_last;
    return v;
  endfunction

  initial begin
    vec_t       tbl [7];
    frame_t     fb;
    int         n;
    int         writes;
    bit         saw_done;
    logic [7:0] last_rd;
    int         sel;

    // Frames run in order; expectations assume each starts from the previous one's state.
    tbl[0] = mk(3, 8'h2A, 8'h2B, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0, 0, 8'h00);
    tbl[1] = mk(4, 8'h2B, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h2B, 1'b1, 1'b0, 3, 8'h00);
    tbl[2] = mk(7, 8'h2B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h2B, 1'b1, 1'b1, 4, 8'h00);
    tbl[3] = mk(1, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0, 0, 8'h00);
    tbl[4] = mk(2, 8'h2A, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C, 1'b0, 1'b0, 0, 8'h00);
    tbl[5] = mk(3, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C, 1'b0, 1'b0, 0, 8'h5C);
    tbl[6] = mk(3, 8'h7F, 8'h2B, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C, 1'b0, 1'b0, 0, 8'h00);

    rst_i = 1'b1;
    repeat (3) tick();
    check("rst_wr_en", 32'(ram_wr_en_o), 32'(0));
    check("rst_wr_addr", 32'(ram_wr_addr_o), 32'(0));
    check("rst_wr_data", 32'(ram_wr_data_o), 32'(0));
    check("rst_conf", 32'(conf_o), 32'(CONF_RST));
    check("rst_done", 32'(frame_done_o), 32'(0));
    check("rst_ovf", 32'(ovf_o), 32'(0));
    check("rst_readback", 32'(spi_byte_data_o), 32'(0));
    rst_i = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_frame(tbl[v].b, tbl[v].n, 0, writes, saw_done, last_rd);
      check($sformatf("tbl%0d_conf", v), 32'(conf_o), 32'(tbl[v].conf));
      check($sformatf("tbl%0d_ovf", v), 32'(ovf_o), 32'(tbl[v].ovf));
      check($sformatf("tbl%0d_done", v), 32'(saw_done), 32'(tbl[v].done));
      check($sformatf("tbl%0d_writes", v), 32'(writes), 32'(tbl[v].writes));
      check($sformatf("tbl%0d_rd_last", v), 32'(last_rd), 32'(tbl[v].rd_last));
    end

    // Last DATA byte arrives in the same cycle the synchronized CS rise is seen.
    spi_cs_n_i = 1'b0;
    repeat (3) tick();
    spi_byte_vld_i = 1'b1; spi_byte_data_i = 8'h2B; tick();
    spi_byte_data_i = 8'h61; tick();
    spi_byte_vld_i = 1'b0;
    check("coin_first_write", 32'(ram_wr_en_o), 32'(1));
    tick();
    spi_cs_n_i = 1'b1;
    tick();
    tick();
    spi_byte_vld_i = 1'b1; spi_byte_data_i = 8'h62; tick();
    spi_byte_vld_i = 1'b0;
    check("coin_wr_en", 32'(ram_wr_en_o), 32'(1));
    check("coin_wr_addr", 32'(ram_wr_addr_o), 32'(1));
    check("coin_wr_data", 32'(ram_wr_data_o), 32'(8'h62));
    check("coin_done", 32'(frame_done_o), 32'(1));
    tick();
    check("coin_done_one_cycle", 32'(frame_done_o), 32'(0));
    m_ovf = 1'b0;

    for (int f = 0; f < 40; f++) begin
      fb  = '0;
      n   = $urandom_range(10, 1);
      sel = $urandom_range(4, 0);
      fb[0] = (sel == 0) ? 8'h2A : (sel == 1) ? 8'h2B : (sel == 2) ? 8'h2C : 8'($urandom);
      for (int k = 1; k < n; k++) begin
        sel = $urandom_range(7, 0);
        fb[k] = (sel == 0) ? 8'h2A : (sel == 1) ? 8'h2B : (sel == 2) ? 8'h2C : 8'($urandom);
      end
      run_frame(fb, n, 2, writes, saw_done, last_rd);
      check("rand_done", 32'(saw_done), 32'(e_done));
    end

    // Reset in the middle of a DATA frame: no pulse may follow.
    spi_cs_n_i = 1'b0;
    repeat (3) tick();
    spi_byte_vld_i = 1'b1; spi_byte_data_i = 8'h2B; tick();
    spi_byte_data_i = 8'h11; tick();
    spi_byte_data_i = 8'h22; tick();
    spi_byte_vld_i = 1'b0;
    check("pre_rst_write", 32'(ram_wr_en_o), 32'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_wr_en", 32'(ram_wr_en_o), 32'(0));
    check("mid_rst_wr_addr", 32'(ram_wr_addr_o), 32'(0));
    check("mid_rst_wr_data", 32'(ram_wr_data_o), 32'(0));
    check("mid_rst_conf", 32'(conf_o), 32'(CONF_RST));
    check("mid_rst_ovf", 32'(ovf_o), 32'(0));
    check("mid_rst_readback", 32'(spi_byte_data_o), 32'(0));
    spi_byte_vld_i = 1'b1; spi_byte_data_i = 8'h33; tick();
    spi_byte_vld_i = 1'b0;
    check("post_rst_no_write", 32'(ram_wr_en_o), 32'(0));
    spi_cs_n_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("post_rst_no_done", 32'(frame_done_o), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
